// File: rtl/tq_recon_sched.sv
// tq_recon_sched: round-robin scheduler/sequencer for the shared 4x4
// dequant + inverse-DCT datapath. Two requesters (0 luma, 1 chroma)
// offer coefficient blocks; the winner is registered into dp_coef_o /
// dp_qp_o for one EXEC cycle, the combinational dp_res_i is captured
// into the output buffer, and the residual is handed downstream.
// Ports: clk_i/rst_n_i (async active-low), flush_i abort,
//   reqN_* requester handshakes and block data, dp_* datapath operand
//   and result, out_* residual handshake, busy_o, sticky qp_clamp_o,
//   blk_cntN_o completed-block counters.
module tq_recon_sched #(
  parameter int COEF_W = 15,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [16*COEF_W-1:0] req0_coef_i,
  input  logic [5:0]           req0_qp_i,
  input  logic                 req0_cbf_i,
  input  logic [TAG_W-1:0]     req0_tag_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [16*COEF_W-1:0] req1_coef_i,
  input  logic [5:0]           req1_qp_i,
  input  logic                 req1_cbf_i,
  input  logic [TAG_W-1:0]     req1_tag_i,
  output logic [16*COEF_W-1:0] dp_coef_o,
  output logic [5:0]           dp_qp_o,
  input  logic [16*COEF_W-1:0] dp_res_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [16*COEF_W-1:0] out_res_o,
  output logic                 out_src_o,
  output logic [TAG_W-1:0]     out_tag_o,
  output logic                 busy_o,
  output logic                 qp_clamp_o,
  output logic [CNT_W-1:0]     blk_cnt0_o,
  output logic [CNT_W-1:0]     blk_cnt1_o
);

  localparam int BW = 16 * COEF_W;
  localparam logic [5:0] QP_MAX = 6'd51;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_OUT
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_out_valid;
  logic              r_qp_clamp;
  logic [BW-1:0]     r_dp_coef;
  logic [5:0]        r_dp_qp;
  logic [BW-1:0]     r_out_res;
  logic              r_out_src;
  logic [TAG_W-1:0]  r_out_tag;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rdy0;
  logic              w_rdy1;
  logic              w_acc;
  logic [BW-1:0]     w_coef;
  logic [5:0]        w_qp;
  logic [5:0]        w_qp_cl;
  logic              w_cbf;
  logic [TAG_W-1:0]  w_tag;

  // On a tie the requester that did not win last time is granted.
  assign w_idle = (r_state == S_IDLE);
  assign w_gnt0 = req0_valid_i && (!req1_valid_i || r_last);
  assign w_gnt1 = req1_valid_i && (!req0_valid_i || !r_last);

  // Gated by rst_n_i so ready stays low while reset is held.
  assign w_rdy0 = rst_n_i && w_idle && !flush_i && w_gnt0;
  assign w_rdy1 = rst_n_i && w_idle && !flush_i && w_gnt1;
  assign w_acc  = w_rdy0 || w_rdy1;

  assign w_coef  = w_rdy1 ? req1_coef_i : req0_coef_i;
  assign w_qp    = w_rdy1 ? req1_qp_i   : req0_qp_i;
  assign w_cbf   = w_rdy1 ? req1_cbf_i  : req0_cbf_i;
  assign w_tag   = w_rdy1 ? req1_tag_i  : req0_tag_i;
  assign w_qp_cl = (w_qp > QP_MAX) ? QP_MAX : w_qp;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_out_valid <= 1'b0;
      r_qp_clamp  <= 1'b0;
      r_dp_coef   <= '0;
      r_dp_qp     <= '0;
      r_out_res   <= '0;
      r_out_src   <= 1'b0;
      r_out_tag   <= '0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else if (flush_i) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_last    <= w_rdy1;
            r_out_src <= w_rdy1;
            r_out_tag <= w_tag;
            if (w_qp > QP_MAX) r_qp_clamp <= 1'b1;
            if (w_cbf) begin
              r_dp_coef <= w_coef;
              r_dp_qp   <= w_qp_cl;
              r_state   <= S_EXEC;
            end else begin
              // Uncoded: skip the datapath, residual is zero.
              r_out_res   <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end
          end
        end
        S_EXEC: begin
          r_out_res   <= dp_res_i;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (r_out_src) r_cnt1 <= r_cnt1 + CNT_W'(1);
            else           r_cnt0 <= r_cnt0 + CNT_W'(1);
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready_o = w_rdy0;
  assign req1_ready_o = w_rdy1;
  assign dp_coef_o    = r_dp_coef;
  assign dp_qp_o      = r_dp_qp;
  assign out_valid_o  = r_out_valid;
  assign out_res_o    = r_out_res;
  assign out_src_o    = r_out_src;
  assign out_tag_o    = r_out_tag;
  assign busy_o       = (r_state != S_IDLE);
  assign qp_clamp_o   = r_qp_clamp;
  assign blk_cnt0_o   = r_cnt0;
  assign blk_cnt1_o   = r_cnt1;

endmodule

// File: tb/tb_tq_recon_sched.sv
// tb_tq_recon_sched: directed bench for tq_recon_sched with a
// scoreboard of expected residual blocks and a stub datapath model.
module tb_tq_recon_sched;

  localparam int CW = 15;
  localparam int TW = 4;
  localparam int NW = 16;
  localparam int BW = 16 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          rdy0, rdy1;
  logic [BW-1:0] c0 = '0, c1 = '0;
  logic [5:0]    q0 = '0, q1 = '0;
  logic          cbf0 = 1'b0, cbf1 = 1'b0;
  logic [TW-1:0] t0 = '0, t1 = '0;
  logic [BW-1:0] dp_coef;
  logic [5:0]    dp_qp;
  logic [BW-1:0] dp_res;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_res;
  logic          out_src;
  logic [TW-1:0] out_tag;
  logic          busy, qp_clamp;
  logic [NW-1:0] cnt0, cnt1;

  typedef struct {
    logic [BW-1:0] res;
    logic          src;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sb[$];
  exp_t          last_e;
  int            checks = 0;
  int            errors = 0;
  logic [NW-1:0] exp_cnt0 = '0, exp_cnt1 = '0;
  logic          exp_clamp = 1'b0;
  logic [BW-1:0] exp_dp = '0;

  always #5 clk = ~clk;

  // Stub datapath: element i = coef_i + qp*(i+1), mod 2^CW.
  function automatic logic [BW-1:0] model(input logic [BW-1:0] c,
                                          input logic [5:0] q);
    logic [BW-1:0] m;
    for (int i = 0; i < 16; i++)
      m[i*CW +: CW] = c[i*CW +: CW] + CW'(q) * CW'(i + 1);
    return m;
  endfunction

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] m;
    for (int i = 0; i < 16; i++)
      m[i*CW +: CW] = CW'($urandom_range(0, 32767));
    return m;
  endfunction

  always_comb dp_res = model(dp_coef, dp_qp);

  tq_recon_sched #(.COEF_W(CW), .TAG_W(TW), .CNT_W(NW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_coef_i(c0),
    .req0_qp_i(q0), .req0_cbf_i(cbf0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_coef_i(c1),
    .req1_qp_i(q1), .req1_cbf_i(cbf1), .req1_tag_i(t1),
    .dp_coef_o(dp_coef), .dp_qp_o(dp_qp), .dp_res_i(dp_res),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_res_o(out_res), .out_src_o(out_src), .out_tag_o(out_tag),
    .busy_o(busy), .qp_clamp_o(qp_clamp),
    .blk_cnt0_o(cnt0), .blk_cnt1_o(cnt1)
  );

  task automatic chk(input string nm, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pop_chk(input string nm);
    chk({nm, "_sb_has"}, 256'(sb.size() != 0), 256'(1));
    if (sb.size() != 0) begin
      last_e = sb.pop_front();
      chk({nm, "_res"}, 256'(out_res), 256'(last_e.res));
      chk({nm, "_src"}, 256'(out_src), 256'(last_e.src));
      chk({nm, "_tag"}, 256'(out_tag), 256'(last_e.tag));
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rdy0"}, 256'(rdy0), 0);
    chk({nm, "_rdy1"}, 256'(rdy1), 0);
    chk({nm, "_oval"}, 256'(out_valid), 0);
    chk({nm, "_ores"}, 256'(out_res), 0);
    chk({nm, "_osrc"}, 256'(out_src), 0);
    chk({nm, "_otag"}, 256'(out_tag), 0);
    chk({nm, "_dpc"}, 256'(dp_coef), 0);
    chk({nm, "_dpq"}, 256'(dp_qp), 0);
    chk({nm, "_busy"}, 256'(busy), 0);
    chk({nm, "_clamp"}, 256'(qp_clamp), 0);
    chk({nm, "_cnt0"}, 256'(cnt0), 0);
    chk({nm, "_cnt1"}, 256'(cnt1), 0);
  endtask

  task automatic set_req(input int n, input logic v,
                         input logic [BW-1:0] c, input logic [5:0] q,
                         input logic cbf, input logic [TW-1:0] t);
    if (n == 0) begin
      v0 = v; c0 = c; q0 = q; cbf0 = cbf; t0 = t;
    end else begin
      v1 = v; c1 = c; q1 = q; cbf1 = cbf; t1 = t;
    end
  endtask

  // Full single-block transaction starting at an IDLE negedge.
  task automatic run_blk(input string nm, input int n,
                         input logic [BW-1:0] c, input logic [5:0] q,
                         input logic cbf, input logic [TW-1:0] t);
    logic [5:0] qc;
    exp_t e;
    qc = (q > 6'd51) ? 6'd51 : q;
    set_req(n, 1'b1, c, q, cbf, t);
    #1;
    chk({nm, "_rdy0"}, 256'(rdy0), 256'(n == 0));
    chk({nm, "_rdy1"}, 256'(rdy1), 256'(n == 1));
    e.res = cbf ? model(c, qc) : '0;
    e.src = 1'(n);
    e.tag = t;
    sb.push_back(e);
    if (q > 6'd51) exp_clamp = 1'b1;
    cyc();
    if (n == 0) v0 = 1'b0; else v1 = 1'b0;
    if (cbf) begin
      exp_dp = c;
      chk({nm, "_exec_busy"}, 256'(busy), 1);
      chk({nm, "_exec_oval"}, 256'(out_valid), 0);
      chk({nm, "_exec_dpq"}, 256'(dp_qp), 256'(qc));
      cyc();
    end
    chk({nm, "_dpc"}, 256'(dp_coef), 256'(exp_dp));
    chk({nm, "_clamp"}, 256'(qp_clamp), 256'(exp_clamp));
    chk({nm, "_oval"}, 256'(out_valid), 1);
    pop_chk(nm);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    if (n == 0) exp_cnt0++; else exp_cnt1++;
    chk({nm, "_cnt0"}, 256'(cnt0), 256'(exp_cnt0));
    chk({nm, "_cnt1"}, 256'(cnt1), 256'(exp_cnt1));
    chk({nm, "_done_oval"}, 256'(out_valid), 0);
    chk({nm, "_done_busy"}, 256'(busy), 0);
  endtask

  initial begin
    logic [BW-1:0] ca, d0, d1, ce, cf;
    exp_t e;
    int who;

    // Reset held with both requesters valid.
    v0 = 1'b1; v1 = 1'b1;
    cyc();
    #1;
    chk_reset("rst");
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single coded block, coef(0,0)=10.
    ca = BW'(10);
    run_blk("single", 0, ca, 6'd28, 1'b1, 4'd3);

    // Uncoded block from req1: dp operand must not move.
    run_blk("uncoded", 1, rnd_blk(), 6'd30, 1'b0, 4'd7);

    // Round robin with both valid and a free consumer.
    d0 = rnd_blk();
    d1 = rnd_blk();
    set_req(0, 1'b1, d0, 6'd10, 1'b1, 4'h8);
    set_req(1, 1'b1, d1, 6'd12, 1'b1, 4'h9);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      who = k % 2;
      #1;
      chk("rr_rdy0", 256'(rdy0), 256'(who == 0));
      chk("rr_rdy1", 256'(rdy1), 256'(who == 1));
      e.res = (who == 1) ? model(d1, 6'd12) : model(d0, 6'd10);
      e.src = 1'(who);
      e.tag = (who == 1) ? t1 : t0;
      sb.push_back(e);
      cyc();
      chk("rr_exec_rdy", 256'({rdy0, rdy1}), 0);
      if (who == 1) t1 = t1 + 1'b1; else t0 = t0 + 1'b1;
      cyc();
      chk("rr_oval", 256'(out_valid), 1);
      pop_chk("rr");
      if (who == 1) exp_cnt1++; else exp_cnt0++;
      if (k == 3) begin v0 = 1'b0; v1 = 1'b0; end
      cyc();
    end
    out_ready = 1'b0;
    exp_dp = d1;
    chk("rr_cnt0", 256'(cnt0), 256'(exp_cnt0));
    chk("rr_cnt1", 256'(cnt1), 256'(exp_cnt1));

    // QP clamp, then sticky across a legal QP.
    run_blk("qp55", 0, rnd_blk(), 6'd55, 1'b1, 4'd2);
    run_blk("qp20", 0, rnd_blk(), 6'd20, 1'b1, 4'd5);

    // Backpressure for 5 cycles, then flush with out_ready high.
    ce = rnd_blk();
    cf = rnd_blk();
    set_req(1, 1'b1, ce, 6'd40, 1'b1, 4'hA);
    #1;
    chk("bp_rdy1", 256'(rdy1), 1);
    e.res = model(ce, 6'd40);
    e.src = 1'b1;
    e.tag = 4'hA;
    sb.push_back(e);
    cyc();
    v1 = 1'b0;
    cyc();
    chk("bp_oval0", 256'(out_valid), 1);
    pop_chk("bp");
    set_req(0, 1'b1, cf, 6'd9, 1'b1, 4'hB);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_oval", 256'(out_valid), 1);
      chk("bp_hold_res", 256'(out_res), 256'(last_e.res));
      chk("bp_hold_src", 256'(out_src), 256'(last_e.src));
      chk("bp_hold_tag", 256'(out_tag), 256'(last_e.tag));
      chk("bp_hold_rdy", 256'({rdy0, rdy1}), 0);
      cyc();
    end
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_rdy", 256'({rdy0, rdy1}), 0);
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("flush_oval", 256'(out_valid), 0);
    chk("flush_busy", 256'(busy), 0);
    chk("flush_cnt1", 256'(cnt1), 256'(exp_cnt1));
    chk("flush_cnt0", 256'(cnt0), 256'(exp_cnt0));
    chk("flush_next_rdy0", 256'(rdy0), 1);
    e.res = model(cf, 6'd9);
    e.src = 1'b0;
    e.tag = 4'hB;
    sb.push_back(e);
    cyc();
    v0 = 1'b0;
    chk("post_flush_dpq", 256'(dp_qp), 9);
    chk("post_flush_clamp", 256'(qp_clamp), 1);
    cyc();
    chk("post_flush_oval", 256'(out_valid), 1);
    pop_chk("post_flush");
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    exp_cnt0++;
    chk("post_flush_cnt0", 256'(cnt0), 256'(exp_cnt0));

    // Asynchronous reset in the middle of EXEC.
    set_req(0, 1'b1, rnd_blk(), 6'd60, 1'b1, 4'd1);
    #1;
    chk("mid_rdy0", 256'(rdy0), 1);
    cyc();
    v1 = 1'b1;
    chk("mid_exec_busy", 256'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    sb.delete();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midrst_tie_rdy0", 256'(rdy0), 1);
    chk("midrst_tie_rdy1", 256'(rdy1), 0);
    v0 = 1'b0;
    v1 = 1'b0;
    cyc();
    chk("sb_empty", 256'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tq_recon_sched.md
# tq_recon_sched

Scheduler and sequencer for the shared 4x4 dequant + inverse-DCT reconstruction datapath in the H.264 transform/quant path. It arbitrates two residual requesters, requester 0 (luma) and requester 1 (chroma), with round-robin priority. It registers one 4x4 coefficient block plus its QP into the combinational datapath and captures the residual result into an output buffer. Blocks with no coded coefficients (cbf=0) bypass the datapath and produce an all-zero residual. The block sits between the entropy-decode/quant stage and the reconstruction adder.

## Interface
Parameters:
- COEF_W, 15, width of one coefficient/residual element
- TAG_W, 4, width of the block index tag carried with each block
- CNT_W, 16, width of the per-requester completed-block counters

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- flush_i  input  1  synchronous abort of the in-flight block
- reqN_valid_i  input  1  requester N (N=0,1) offers a block
- reqN_ready_o  output  1  block accepts requester N this cycle
- reqN_coef_i  input  16*COEF_W  4x4 block; element (r,c) at bits [(4r+c)*COEF_W +: COEF_W]
- reqN_qp_i  input  6  block QP
- reqN_cbf_i  input  1  1 = coded block, 0 = all-zero block
- reqN_tag_i  input  TAG_W  block index
- dp_coef_o  output  16*COEF_W  operand to datapath, same packing
- dp_qp_o  output  6  QP to datapath (clamped)
- dp_res_i  input  16*COEF_W  datapath residual, combinational from dp_coef_o/dp_qp_o
- out_valid_o  output  1  residual block available
- out_ready_i  input  1  consumer accepts residual
- out_res_o  output  16*COEF_W  residual block, same packing
- out_src_o  output  1  requester that produced the block
- out_tag_o  output  TAG_W  tag of the block
- busy_o  output  1  state != IDLE
- qp_clamp_o  output  1  sticky: a QP > 51 was accepted
- blk_cnt0_o, blk_cnt1_o  output  CNT_W  completed blocks per requester

## Operation
- FSM states: IDLE, EXEC, OUT.
- IDLE: the winner of any valid requester is granted. reqN_ready_o = (state==IDLE) && grant==N && !flush_i; it is combinational. At most one ready is high.
- Round-robin: pointer last_grant, reset 1, so requester 0 wins the first tie. On a tie the non-last requester wins. The pointer updates only on accept.
- Accept (valid && ready):
  - Latch coef, qp, tag and src.
  - cbf=1: go to EXEC.
  - cbf=0: load out_res = 0 and go to OUT. dp_* are not reloaded.
- QP clamp: qp>51 → dp_qp_o=51 and qp_clamp_o set. It clears only on reset.
- EXEC: dp_coef_o/dp_qp_o hold the latched operand. At the end of the cycle, dp_res_i is captured into out_res_o, and the state goes to OUT.
- OUT: out_valid_o=1. out_res_o, out_src_o and out_tag_o are stable until the handshake. On out_valid_o && out_ready_i, increment blk_cnt[src] (wraps modulo 2^CNT_W) and go to IDLE.
- No accept happens in OUT. The new grant is evaluated in the IDLE cycle that follows.
- flush_i has the highest priority:
  - From any state, go to IDLE next cycle and clear out_valid_o.
  - No counter increments, even if out_ready_i is high in the same cycle.
  - No ready asserted during the flush cycle.
  - The pointer and qp_clamp_o are unchanged.
- dp_coef_o/dp_qp_o keep their last loaded value outside EXEC.

## Timing
- Reset values: all ready=0, out_valid_o=0, out_res_o=0, out_src_o=0, out_tag_o=0, dp_coef_o=0, dp_qp_o=0, busy_o=0, qp_clamp_o=0, counters 0, state IDLE.
- Coded block: accept in cycle T, EXEC in T+1, out_valid_o high from T+2.
- Uncoded block: accept in T, out_valid_o high from T+1.
- With out_ready_i held high, the issue intervals are:
  - coded: one accept every 3 cycles (T, T+3, ...);
  - uncoded: one accept every 2 cycles.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously). The in-flight block is lost.

## Test plan
- Single coded block from req0: qp=28, coef(0,0)=10, rest 0, tag=3. Required:
  - ready high in T;
  - dp_qp_o=28 in T+1;
  - out_valid_o at T+2 with out_res_o equal to dp_res_i sampled in T+1, out_src_o=0, out_tag_o=3;
  - blk_cnt0_o=1 after the handshake.
- Both requesters valid continuously, 4 coded blocks with out_ready_i=1. Required grant order 0,1,0,1 and accepts at T, T+3, T+6, T+9.
- req1 with cbf=0, tag=7. Required: out_valid_o at T+1, out_res_o all zero, dp_coef_o unchanged, blk_cnt1_o increments.
- req0 qp=55. Required: dp_qp_o=51 in EXEC, qp_clamp_o=1; it stays 1 after later qp=20 blocks.
- Backpressure and flush:
  - out_ready_i=0 for 5 cycles in OUT: out_* stable and no ready asserted.
  - flush_i together with out_ready_i=1: out_valid_o=0 next cycle and no counter change.
  - The next request is accepted in the following IDLE cycle.
- Assert rst_n_i during EXEC. Required: all outputs at reset values immediately; after release, req0 wins a tie.
